// File: rtl/vga_sprite_scheduler.sv
// vga_sprite_scheduler: scans the sprite table for the next scanline, fetches
// pattern rows into shadow slots and commits them atomically on line_start.
module vga_sprite_scheduler #(
    parameter int NUM_SPRITES = 8,
    parameter int NUM_SLOTS   = 3,
    parameter int IDX_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_start,
    input  logic [9:0]              next_line_y,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_index,
    input  logic                    cfg_enable,
    input  logic [9:0]              cfg_x,
    input  logic [9:0]              cfg_y,
    input  logic [5:0]              cfg_size,
    input  logic [1:0]              cfg_vshift,
    input  logic [3:0]              cfg_pattern,
    output logic [7:0]              pat_addr,
    input  logic [31:0]             pat_data,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [32*NUM_SLOTS-1:0] slot_pixels,
    output logic [6*NUM_SLOTS-1:0]  slot_size,
    output logic [10*NUM_SLOTS-1:0] slot_start,
    output logic                    scan_busy,
    output logic                    overflow
);

    localparam int CNT_W = $clog2(NUM_SLOTS + 1);
    localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FETCH, CAPTURE} state_t;

    typedef struct packed {
        logic       valid;
        logic [31:0] pixels;
        logic [5:0] size;
        logic [9:0] start;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, pixels: 32'h0,
                                     size: 6'h0, start: 10'h3FF};

    logic       ten_q  [NUM_SPRITES];
    logic [9:0] tx_q   [NUM_SPRITES];
    logic [9:0] ty_q   [NUM_SPRITES];
    logic [5:0] tsz_q  [NUM_SPRITES];
    logic [1:0] tvs_q  [NUM_SPRITES];
    logic [3:0] tpat_q [NUM_SPRITES];

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [9:0]       liney_q, liney_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [9:0]       lx_q, lx_d;
    logic [5:0]       lsz_q, lsz_d;
    logic             ovf_q, ovf_d;
    slot_t            sh_q  [NUM_SLOTS];
    slot_t            sh_d  [NUM_SLOTS];
    slot_t            out_q [NUM_SLOTS];
    slot_t            out_d [NUM_SLOTS];

    logic [10:0] dy;
    logic [10:0] height;
    logic        hit;
    logic [3:0]  row;
    logic        last;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                ten_q[i]  <= 1'b0;
                tx_q[i]   <= '0;
                ty_q[i]   <= '0;
                tsz_q[i]  <= '0;
                tvs_q[i]  <= '0;
                tpat_q[i] <= '0;
            end
        end else if (cfg_we) begin
            ten_q[cfg_index]  <= cfg_enable;
            tx_q[cfg_index]   <= cfg_x;
            ty_q[cfg_index]   <= cfg_y;
            tsz_q[cfg_index]  <= cfg_size;
            tvs_q[cfg_index]  <= cfg_vshift;
            tpat_q[cfg_index] <= cfg_pattern;
        end
    end

    // Hit test in 11 bits so a sprite above the line never wraps into view.
    always_comb begin
        dy     = {1'b0, liney_q} - {1'b0, ty_q[idx_q]};
        height = 11'd16 << tvs_q[idx_q];
        hit    = ten_q[idx_q] && (liney_q >= ty_q[idx_q]) && (dy < height);
        row    = dy[3:0];
        unique case (tvs_q[idx_q])
            2'd0: row = dy[3:0];
            2'd1: row = dy[4:1];
            2'd2: row = dy[5:2];
            2'd3: row = dy[6:3];
            default: row = dy[3:0];
        endcase
        last = (idx_q == LAST_C);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        liney_d = liney_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        lx_d    = lx_q;
        lsz_d   = lsz_q;
        ovf_d   = ovf_q;
        sh_d    = sh_q;
        out_d   = out_q;
        if (line_start) begin
            // Commit only finished captures; any fetch in flight is dropped.
            out_d = sh_q;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                sh_d[k] = SLOT_EMPTY;
            end
            cnt_d   = '0;
            idx_d   = '0;
            liney_d = next_line_y;
            state_d = SCAN;
        end else begin
            unique case (state_q)
                IDLE: ;
                SCAN: begin
                    if (hit && (cnt_q < SLOTS_C)) begin
                        addr_d  = {tpat_q[idx_q], row};
                        lx_d    = tx_q[idx_q];
                        lsz_d   = tsz_q[idx_q];
                        state_d = FETCH;
                    end else begin
                        if (hit) begin
                            ovf_d = 1'b1;
                        end
                        idx_d   = idx_q + 1'b1;
                        state_d = last ? IDLE : SCAN;
                    end
                end
                FETCH: state_d = CAPTURE;
                CAPTURE: begin
                    sh_d[cnt_q] = '{valid: 1'b1, pixels: pat_data,
                                    size: lsz_q, start: lx_q};
                    cnt_d   = cnt_q + 1'b1;
                    idx_d   = idx_q + 1'b1;
                    state_d = last ? IDLE : SCAN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            liney_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            lx_q    <= '0;
            lsz_q   <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                sh_q[k]  <= SLOT_EMPTY;
                out_q[k] <= SLOT_EMPTY;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            liney_q <= liney_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            lx_q    <= lx_d;
            lsz_q   <= lsz_d;
            ovf_q   <= ovf_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        slot_valid  = '0;
        slot_pixels = '0;
        slot_size   = '0;
        slot_start  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            slot_valid[k]          = out_q[k].valid;
            slot_pixels[32*k +: 32] = out_q[k].pixels;
            slot_size[6*k +: 6]     = out_q[k].size;
            slot_start[10*k +: 10]  = out_q[k].start;
        end
    end

    assign pat_addr  = addr_q;
    assign scan_busy = (state_q != IDLE);
    assign overflow  = ovf_q;

endmodule
